// File: rtl/hash_msg_streamer_pkg.sv
// Shared types and widths for the hash message streamer.
//   stream_state_t : streamer FSM states
//   CNT_W          : width of the core length (counter) bus
//   DIG_W          : width of the core digest
//   BYTE_W         : width of one message byte
package hash_stream_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    STREAM      = 3'd1,
    GAP         = 3'd2,
    WAIT_DIGEST = 3'd3,
    OUT         = 3'd4
  } stream_state_t;

  localparam int CNT_W  = 64;
  localparam int DIG_W  = 32;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/hash_msg_streamer_buf.sv
// msg_byte_buffer: DEPTH x BYTE_W message store.
//   clk   : clock
//   we    : write enable (synchronous write)
//   waddr : write address
//   wdata : write byte
//   raddr : read address (combinational read)
//   rdata : read byte
// Storage is deliberately not reset; the streamer tracks validity with its own length.
module msg_byte_buffer
  import hash_stream_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [BYTE_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [BYTE_W-1:0]        rdata
);

  logic [BYTE_W-1:0] mem_r [DEPTH];

  // Byte write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/hash_msg_streamer.sv
// hash_msg_streamer: buffers one host message and replays it to the hash core,
// one core_m_valid pulse every BYTE_GAP cycles, then returns the digest to the host.
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_data/in_last/in_ready : host byte stream
//   core_message/core_m_valid/core_counter : core byte feed and message length
//   core_digest/core_hash_rdy       : core result
//   digest_valid/digest/digest_ready : host digest handshake
//   err_overflow/err_timeout/err_clr : sticky error flags and their clear
module hash_msg_streamer
  import hash_stream_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int BYTE_GAP = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [BYTE_W-1:0] core_message,
  output logic              core_m_valid,
  output logic [CNT_W-1:0]  core_counter,
  input  logic [DIG_W-1:0]  core_digest,
  input  logic              core_hash_rdy,
  output logic              digest_valid,
  output logic [DIG_W-1:0]  digest,
  input  logic              digest_ready,
  output logic              err_overflow,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(BYTE_GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] LEN_FULL_M1 = PW'(DEPTH - 1);
  localparam logic [GW-1:0] GAP_END     = GW'((BYTE_GAP >= 2) ? (BYTE_GAP - 2) : 0);
  localparam logic [TW-1:0] TIMER_END   = TW'(TIMEOUT - 1);

  stream_state_t     state_r, state_s;
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r, len_r;
  logic [PW-1:0]     len_inc_s, rd_inc_s;
  logic [GW-1:0]     gap_cnt_r;
  logic [TW-1:0]     timer_r;
  logic              armed_r, in_ready_r;
  logic [BYTE_W-1:0] core_message_r, buf_rdata_s;
  logic              core_m_valid_r;
  logic [CNT_W-1:0]  core_counter_r;
  logic              digest_valid_r;
  logic [DIG_W-1:0]  digest_r;
  logic              err_overflow_r, err_timeout_r;
  logic              accept_s, finish_s, overflow_s, capture_s, timeout_s, release_s;
  logic              stream_s, busy_s;

  assign len_inc_s = len_r + PW'(1);
  assign rd_inc_s  = rd_ptr_r + PW'(1);
  assign stream_s  = (state_r == STREAM);
  assign busy_s    = (state_r == STREAM) || (state_r == GAP) || (state_r == WAIT_DIGEST);

  msg_byte_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (accept_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (buf_rdata_s)
  );

  // Next-state logic and single-cycle event strobes.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    finish_s   = 1'b0;
    overflow_s = 1'b0;
    capture_s  = 1'b0;
    timeout_s  = 1'b0;
    release_s  = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = in_valid & in_ready_r;
        if (accept_s && in_last) begin
          finish_s = 1'b1;
          state_s  = STREAM;
        end else if (accept_s && (len_r == LEN_FULL_M1)) begin
          overflow_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        // With BYTE_GAP==1 the pulses run back-to-back, so GAP is skipped.
        if (BYTE_GAP > 1) begin
          state_s = GAP;
        end else if (rd_inc_s == len_r) begin
          state_s = WAIT_DIGEST;
        end else begin
          state_s = STREAM;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_END) begin
          if (rd_ptr_r == len_r) begin
            state_s = WAIT_DIGEST;
          end else begin
            state_s = STREAM;
          end
        end else begin
          state_s = GAP;
        end
      end
      WAIT_DIGEST: begin
        // A digest counts only after hash_ready has been seen low for this message.
        if (armed_r && core_hash_rdy) begin
          capture_s = 1'b1;
          state_s   = OUT;
        end else if (timer_r == TIMER_END) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = WAIT_DIGEST;
        end
      end
      OUT: begin
        if (digest_ready) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered in_ready (low in the first cycle after reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == IDLE);
    end
  end

  // Write/read pointers and message length; cleared when a message is dropped or finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      len_r    <= '0;
    end else if (overflow_s || timeout_s || release_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      len_r    <= '0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
        len_r    <= len_inc_s;
      end
      if (stream_s) begin
        rd_ptr_r <= rd_inc_s;
      end
    end
  end

  // Core-facing byte, pulse and length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_message_r <= '0;
      core_m_valid_r <= 1'b0;
      core_counter_r <= '0;
    end else begin
      core_m_valid_r <= stream_s;
      if (stream_s) begin
        core_message_r <= buf_rdata_s;
      end
      if (finish_s) begin
        core_counter_r <= {{(CNT_W - PW){1'b0}}, len_inc_s};
      end
    end
  end

  // Byte-gap counter, digest wait timer and hash_ready arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_r <= '0;
      timer_r   <= '0;
      armed_r   <= 1'b0;
    end else begin
      if (stream_s) begin
        gap_cnt_r <= '0;
      end else if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r + GW'(1);
      end
      if (state_r == WAIT_DIGEST) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= '0;
      end
      if (finish_s) begin
        armed_r <= 1'b0;
      end else if (busy_s && !core_hash_rdy) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Digest capture and host-side valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest_r       <= '0;
      digest_valid_r <= 1'b0;
    end else if (capture_s) begin
      digest_r       <= core_digest;
      digest_valid_r <= 1'b1;
    end else if (release_s) begin
      digest_valid_r <= 1'b0;
    end
  end

  // Sticky errors; a new error event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_r <= 1'b0;
      err_timeout_r  <= 1'b0;
    end else begin
      err_overflow_r <= overflow_s | (err_overflow_r & ~err_clr);
      err_timeout_r  <= timeout_s  | (err_timeout_r  & ~err_clr);
    end
  end

  assign in_ready     = in_ready_r;
  assign core_message = core_message_r;
  assign core_m_valid = core_m_valid_r;
  assign core_counter = core_counter_r;
  assign digest_valid = digest_valid_r;
  assign digest       = digest_r;
  assign err_overflow = err_overflow_r;
  assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_hash_msg_streamer.sv
// Randomized self-checking bench for hash_msg_streamer with a behavioural core model.
module tb_hash_msg_streamer;

  localparam int DEPTH    = 64;
  localparam int BYTE_GAP = 3;
  localparam int TIMEOUT  = 255;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  core_message;
  logic        core_m_valid;
  logic [63:0] core_counter;
  logic [31:0] core_digest = 32'h0;
  logic        core_hash_rdy = 1'b1;
  logic        digest_valid;
  logic [31:0] digest;
  logic        digest_ready = 1'b0;
  logic        err_overflow;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  hash_msg_streamer #(.DEPTH(DEPTH), .BYTE_GAP(BYTE_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .core_message(core_message), .core_m_valid(core_m_valid), .core_counter(core_counter),
    .core_digest(core_digest), .core_hash_rdy(core_hash_rdy),
    .digest_valid(digest_valid), .digest(digest), .digest_ready(digest_ready),
    .err_overflow(err_overflow), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed core traffic and core-model controls.
  logic [7:0]  pulse_b[$];
  longint      pulse_t[$];
  logic [63:0] pulse_c[$];
  bit          dv_seen = 1'b0;
  longint      err_to_t = -1;
  int          core_len = 0;
  bit          core_resp = 1'b1;
  logic [31:0] core_dig = 32'h0;
  int          npulse = 0;
  int          rdy_dly = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor plus hash-core model: drops hash_ready on each byte, raises it
  // with the digest 2 cycles after the final byte when asked to respond.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      npulse        = 0;
      rdy_dly       = 0;
      core_hash_rdy = 1'b1;
    end else begin
      if (digest_valid) dv_seen = 1'b1;
      if (err_timeout && err_to_t < 0) err_to_t = cyc;
      if (core_m_valid) begin
        pulse_b.push_back(core_message);
        pulse_t.push_back(cyc);
        pulse_c.push_back(core_counter);
        npulse++;
        core_hash_rdy = 1'b0;
        core_digest   = ~core_dig;
        if (core_resp && npulse == core_len) rdy_dly = 2;
      end else if (rdy_dly > 0) begin
        rdy_dly--;
        if (rdy_dly == 0) begin
          core_digest   = core_dig;
          core_hash_rdy = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] d, input logic last);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_eq("in_ready_wait", {63'h0, in_ready}, 64'h1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic arm_core(input int n, input bit respond, input logic [31:0] dig);
    pulse_b.delete();
    pulse_t.delete();
    pulse_c.delete();
    npulse    = 0;
    dv_seen   = 1'b0;
    err_to_t  = -1;
    core_len  = n;
    core_resp = respond;
    core_dig  = dig;
  endtask

  // Send a message, check the replayed bytes, then either the digest handshake or the timeout.
  task automatic run_msg(input bq_t msg, input bit respond, input logic [31:0] dig, input string tag);
    int n = msg.size();
    int k = 0;
    arm_core(n, respond, dig);
    for (int i = 0; i < n; i++) put_byte(msg[i], (i == n - 1));
    while (pulse_b.size() < n && k < n * BYTE_GAP + 40) begin
      tick();
      k++;
    end
    repeat (BYTE_GAP + 1) tick();
    check_eq({tag, "_npulse"}, 64'(pulse_b.size()), 64'(n));
    for (int i = 0; i < pulse_b.size() && i < n; i++) begin
      check_eq({tag, "_byte"}, {56'h0, pulse_b[i]}, {56'h0, msg[i]});
      check_eq({tag, "_counter"}, pulse_c[i], 64'(n));
      if (i > 0) check_eq({tag, "_spacing"}, 64'(pulse_t[i] - pulse_t[i-1]), 64'(BYTE_GAP));
    end
    if (respond) begin
      k = 0;
      while (!digest_valid && k < 40) begin
        tick();
        k++;
      end
      for (int j = 0; j < 5; j++) begin
        check_eq({tag, "_dvalid_hold"}, {63'h0, digest_valid}, 64'h1);
        check_eq({tag, "_digest"}, {32'h0, digest}, {32'h0, dig});
        tick();
      end
      digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      check_eq({tag, "_dvalid_drop"}, {63'h0, digest_valid}, 64'h0);
      check_eq({tag, "_ready_after"}, {63'h0, in_ready}, 64'h1);
    end else begin
      k = 0;
      while (!err_timeout && k < TIMEOUT + 60) begin
        tick();
        k++;
      end
      check_eq({tag, "_err_timeout"}, {63'h0, err_timeout}, 64'h1);
      // Wait spans the rest of the last byte slot, then TIMEOUT cycles of waiting.
      if (pulse_t.size() > 0 && err_to_t >= 0)
        check_eq({tag, "_to_latency"}, 64'(err_to_t - pulse_t[pulse_t.size()-1]),
                 64'(BYTE_GAP - 1 + TIMEOUT));
      check_eq({tag, "_dv_never"}, {63'h0, dv_seen}, 64'h0);
      check_eq({tag, "_ready_idle"}, {63'h0, in_ready}, 64'h1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_eq({tag, "_to_clr"}, {63'h0, err_timeout}, 64'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, {63'h0, in_ready}, 64'h0);
    check_eq({tag, "_m_valid"}, {63'h0, core_m_valid}, 64'h0);
    check_eq({tag, "_message"}, {56'h0, core_message}, 64'h0);
    check_eq({tag, "_counter"}, core_counter, 64'h0);
    check_eq({tag, "_dvalid"}, {63'h0, digest_valid}, 64'h0);
    check_eq({tag, "_digest"}, {32'h0, digest}, 64'h0);
    check_eq({tag, "_err_ovf"}, {63'h0, err_overflow}, 64'h0);
    check_eq({tag, "_err_to"}, {63'h0, err_timeout}, 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int  k;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready_first_cycle", {63'h0, in_ready}, 64'h0);
    tick();
    check_eq("ready_idle", {63'h0, in_ready}, 64'h1);

    q = '{8'h41};
    run_msg(q, 1'b1, $urandom, "one");
    q = '{8'h61, 8'h62, 8'h63, 8'h64};
    run_msg(q, 1'b1, 32'hDEADBEEF, "abcd");

    for (int m = 0; m < 6; m++) begin
      q.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) q.push_back(8'($urandom));
      run_msg(q, 1'b1, $urandom, "rnd");
    end

    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
    run_msg(q, 1'b1, $urandom, "full");

    // DEPTH bytes without in_last: message dropped, nothing streamed.
    arm_core(0, 1'b1, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      put_byte(8'($urandom), 1'b0);
      if (i == DEPTH - 2) check_eq("ovf_early", {63'h0, err_overflow}, 64'h0);
    end
    check_eq("ovf_set", {63'h0, err_overflow}, 64'h1);
    check_eq("ovf_ready", {63'h0, in_ready}, 64'h1);
    repeat (10) tick();
    check_eq("ovf_no_pulse", 64'(pulse_b.size()), 64'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("ovf_clr", {63'h0, err_overflow}, 64'h0);
    q = '{8'h11, 8'h22};
    run_msg(q, 1'b1, $urandom, "post_ovf");

    q = '{8'h5a, 8'ha5};
    run_msg(q, 1'b0, 32'h0, "tmo");
    q = '{8'h33};
    run_msg(q, 1'b1, $urandom, "post_tmo");

    // Reset in the gap after the first byte of a 3-byte message.
    arm_core(3, 1'b1, $urandom);
    put_byte(8'h01, 1'b0);
    put_byte(8'h02, 1'b0);
    put_byte(8'h03, 1'b1);
    k = 0;
    while (pulse_b.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_ready_first", {63'h0, in_ready}, 64'h0);
    tick();
    repeat (10) tick();
    check_eq("midrst_no_more_pulses", 64'(pulse_b.size()), 64'h1);
    check_eq("midrst_ready", {63'h0, in_ready}, 64'h1);
    q = '{8'hc1, 8'hc2, 8'hc3};
    run_msg(q, 1'b1, $urandom, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
